// File: rtl/raster_pkg.sv
// Shared state encoding, screen defaults and address helper for the line rasterizer.
package raster_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, RUN} raster_state_t;

  localparam int DEF_SCREEN_W = 640;
  localparam int DEF_SCREEN_H = 480;
  localparam int LANE_INC_W   = 4;

  // 640 = 512 + 128, so the common framebuffer width needs no multiplier.
  function automatic logic [31:0] coord_to_addr(input logic [31:0] x, input logic [31:0] y,
                                                input int unsigned scr_w);
    if (scr_w == 32'd640) return (y << 9) + (y << 7) + x;
    return y * scr_w + x;
  endfunction

endpackage

// File: rtl/bresenham_lanes.sv
// Combinational LANES-deep Bresenham error chain: minor-axis offset of every lane
// relative to the beat's first pixel, plus the error after all LANES steps.
module bresenham_lanes
  import raster_pkg::*;
#(
  parameter int LANES = 2,
  parameter int W     = 16
) (
  input  logic [W-1:0]                     err,
  input  logic [W-1:0]                     dmin2,
  input  logic [W-1:0]                     dmaj2,
  output logic [LANES-1:0][LANE_INC_W-1:0] lane_inc,
  output logic [LANE_INC_W-1:0]            inc_total,
  output logic [W-1:0]                     err_next
);

  logic [W-1:0]          e;
  logic [LANE_INC_W-1:0] cnt;

  // err stays in [0, dmaj2), and dmin2 <= dmaj2, so one subtract per step suffices.
  always_comb begin
    e        = err;
    cnt      = '0;
    lane_inc = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_inc[i] = cnt;
      e = e + dmin2;
      if (e >= dmaj2) begin
        e   = e - dmaj2;
        cnt = cnt + LANE_INC_W'(1);
      end
    end
    err_next  = e;
    inc_total = cnt;
  end

endmodule

// File: rtl/line_raster_lanes.sv
// Multi-lane Bresenham line rasterizer: takes one centre-origin line command and
// streams LANES major-axis pixels per beat with clip masks and framebuffer addresses.
module line_raster_lanes
  import raster_pkg::*;
#(
  parameter int LANES    = 2,
  parameter int COORD_W  = 13,
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter int ADDR_W   = 19,
  parameter int COLOR_W  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [COORD_W-1:0]        start_x,
  input  logic [COORD_W-1:0]        start_y,
  input  logic [COORD_W-1:0]        end_x,
  input  logic [COORD_W-1:0]        end_y,
  input  logic [COLOR_W-1:0]        color,
  output logic                      pix_valid,
  input  logic                      pix_ready,
  output logic [LANES-1:0]          pix_mask,
  output logic [LANES*COORD_W-1:0]  pix_x,
  output logic [LANES*COORD_W-1:0]  pix_y,
  output logic [LANES*ADDR_W-1:0]   pix_addr,
  output logic [COLOR_W-1:0]        pix_color,
  output logic                      pix_last,
  output logic                      busy
);

  localparam int W  = COORD_W + 1;
  localparam int EW = COORD_W + 3;
  localparam logic [W-1:0] HALF_W  = W'(SCREEN_W / 2);
  localparam logic [W-1:0] HALF_H  = W'(SCREEN_H / 2);
  localparam logic [W-1:0] LANES_W = W'(LANES);

  raster_state_t      state_q, state_d;
  logic [COORD_W-1:0] x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
  logic [COLOR_W-1:0] color_q, color_d;
  logic [W-1:0]       maj_q, maj_d, min_q, min_d, left_q, left_d;
  logic [EW-1:0]      err_q, err_d, dmin2_q, dmin2_d, dmaj2_q, dmaj2_d;
  logic               maj_neg_q, maj_neg_d, min_neg_q, min_neg_d, x_major_q, x_major_d;

  logic [W-1:0] sx, sy, ex, ey, dx_s, dy_s, dx, dy, dmaj, dmin;
  logic         x_major, run, last_beat;

  logic [LANES-1:0][LANE_INC_W-1:0] lane_inc;
  logic [LANE_INC_W-1:0]            inc_total;
  logic [EW-1:0]                    err_next;

  // Screen-space geometry of the latched command, one bit wider so extremes never wrap.
  always_comb begin
    sx      = {x0_q[COORD_W-1], x0_q} + HALF_W;
    sy      = HALF_H - {y0_q[COORD_W-1], y0_q};
    ex      = {x1_q[COORD_W-1], x1_q} + HALF_W;
    ey      = HALF_H - {y1_q[COORD_W-1], y1_q};
    dx_s    = ex - sx;
    dy_s    = ey - sy;
    dx      = dx_s[W-1] ? -dx_s : dx_s;
    dy      = dy_s[W-1] ? -dy_s : dy_s;
    x_major = (dx >= dy);
    dmaj    = x_major ? dx : dy;
    dmin    = x_major ? dy : dx;
  end

  assign run       = (state_q == RUN);
  assign last_beat = (left_q < LANES_W);

  bresenham_lanes #(.LANES(LANES), .W(EW)) u_chain (
    .err       (err_q),
    .dmin2     (dmin2_q),
    .dmaj2     (dmaj2_q),
    .lane_inc  (lane_inc),
    .inc_total (inc_total),
    .err_next  (err_next)
  );

  always_comb begin
    state_d   = state_q;
    x0_d      = x0_q;
    y0_d      = y0_q;
    x1_d      = x1_q;
    y1_d      = y1_q;
    color_d   = color_q;
    maj_d     = maj_q;
    min_d     = min_q;
    left_d    = left_q;
    err_d     = err_q;
    dmin2_d   = dmin2_q;
    dmaj2_d   = dmaj2_q;
    maj_neg_d = maj_neg_q;
    min_neg_d = min_neg_q;
    x_major_d = x_major_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          x0_d    = start_x;
          y0_d    = start_y;
          x1_d    = end_x;
          y1_d    = end_y;
          color_d = color;
          state_d = SETUP;
        end
      end
      SETUP: begin
        x_major_d = x_major;
        maj_d     = x_major ? sx : sy;
        min_d     = x_major ? sy : sx;
        maj_neg_d = x_major ? dx_s[W-1] : dy_s[W-1];
        min_neg_d = x_major ? dy_s[W-1] : dx_s[W-1];
        dmaj2_d   = {1'b0, dmaj, 1'b0};
        dmin2_d   = {1'b0, dmin, 1'b0};
        // Starting at dmaj gives the round-half-away-from-start minor step.
        err_d     = {2'b00, dmaj};
        left_d    = dmaj;
        state_d   = RUN;
      end
      RUN: begin
        if (pix_ready) begin
          maj_d  = maj_neg_q ? maj_q - LANES_W : maj_q + LANES_W;
          min_d  = min_neg_q ? min_q - W'(inc_total) : min_q + W'(inc_total);
          err_d  = err_next;
          left_d = left_q - LANES_W;
          if (last_beat) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      x0_q      <= '0;
      y0_q      <= '0;
      x1_q      <= '0;
      y1_q      <= '0;
      color_q   <= '0;
      maj_q     <= '0;
      min_q     <= '0;
      left_q    <= '0;
      err_q     <= '0;
      dmin2_q   <= '0;
      dmaj2_q   <= '0;
      maj_neg_q <= 1'b0;
      min_neg_q <= 1'b0;
      x_major_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x0_q      <= x0_d;
      y0_q      <= y0_d;
      x1_q      <= x1_d;
      y1_q      <= y1_d;
      color_q   <= color_d;
      maj_q     <= maj_d;
      min_q     <= min_d;
      left_q    <= left_d;
      err_q     <= err_d;
      dmin2_q   <= dmin2_d;
      dmaj2_q   <= dmaj2_d;
      maj_neg_q <= maj_neg_d;
      min_neg_q <= min_neg_d;
      x_major_q <= x_major_d;
    end
  end

  logic [W-1:0]      lane_maj, lane_min, lane_x, lane_y;
  logic              lane_on;
  logic [ADDR_W-1:0] lane_addr;

  // Beat payload derives only from registers that move on transfer, so it holds while stalled.
  always_comb begin
    pix_mask  = '0;
    pix_x     = '0;
    pix_y     = '0;
    pix_addr  = '0;
    lane_maj  = '0;
    lane_min  = '0;
    lane_x    = '0;
    lane_y    = '0;
    lane_on   = 1'b0;
    lane_addr = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_maj  = maj_neg_q ? maj_q - W'(i) : maj_q + W'(i);
      lane_min  = min_neg_q ? min_q - W'(lane_inc[i]) : min_q + W'(lane_inc[i]);
      lane_x    = x_major_q ? lane_maj : lane_min;
      lane_y    = x_major_q ? lane_min : lane_maj;
      lane_on   = run && (W'(i) <= left_q) &&
                  !lane_x[W-1] && (lane_x < W'(SCREEN_W)) &&
                  !lane_y[W-1] && (lane_y < W'(SCREEN_H));
      lane_addr = ADDR_W'(coord_to_addr(32'(lane_x), 32'(lane_y), SCREEN_W));
      if (run) begin
        pix_mask[i]                   = lane_on;
        pix_x[i*COORD_W +: COORD_W]   = lane_x[COORD_W-1:0];
        pix_y[i*COORD_W +: COORD_W]   = lane_y[COORD_W-1:0];
        pix_addr[i*ADDR_W +: ADDR_W]  = lane_on ? lane_addr : '0;
      end
    end
  end

  assign pix_valid = run;
  assign pix_last  = run && last_beat;
  assign pix_color = run ? color_q : '0;
  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_line_raster_lanes.sv
// Scoreboard bench for line_raster_lanes: a reference model built from the closed-form
// pixel formula queues expected beats, which are popped as the DUT transfers them.
module tb_line_raster_lanes;

  localparam int LANES    = 2;
  localparam int COORD_W  = 13;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int ADDR_W   = 19;
  localparam int COLOR_W  = 4;

  typedef struct {
    logic [LANES-1:0]               mask;
    logic [LANES-1:0]               chk;
    logic [LANES-1:0][COORD_W-1:0]  x;
    logic [LANES-1:0][COORD_W-1:0]  y;
    logic [LANES-1:0][ADDR_W-1:0]   addr;
    logic                           last;
    logic [COLOR_W-1:0]             color;
  } beat_t;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [COORD_W-1:0]       start_x, start_y, end_x, end_y;
  logic [COLOR_W-1:0]       color;
  logic                     pix_valid;
  logic                     pix_ready;
  logic [LANES-1:0]         pix_mask;
  logic [LANES*COORD_W-1:0] pix_x, pix_y;
  logic [LANES*ADDR_W-1:0]  pix_addr;
  logic [COLOR_W-1:0]       pix_color;
  logic                     pix_last;
  logic                     busy;

  int    compared   = 0;
  int    mismatched = 0;
  beat_t sb[$];

  line_raster_lanes #(
    .LANES(LANES), .COORD_W(COORD_W), .SCREEN_W(SCREEN_W),
    .SCREEN_H(SCREEN_H), .ADDR_W(ADDR_W), .COLOR_W(COLOR_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .start_x(start_x), .start_y(start_y), .end_x(end_x), .end_y(end_y), .color(color),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_mask(pix_mask),
    .pix_x(pix_x), .pix_y(pix_y), .pix_addr(pix_addr), .pix_color(pix_color),
    .pix_last(pix_last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic push_line(input int x0, input int y0, input int x1, input int y1,
                           input logic [COLOR_W-1:0] col);
    int sx, sy, ex, ey, dx, dy, dmaj, dmin, smaj, smin, gmaj, gmin, nb, k, m, a, c, px, py;
    bit xmaj, on;
    beat_t e;
    sx = x0 + SCREEN_W / 2;
    sy = SCREEN_H / 2 - y0;
    ex = x1 + SCREEN_W / 2;
    ey = SCREEN_H / 2 - y1;
    dx = (ex >= sx) ? ex - sx : sx - ex;
    dy = (ey >= sy) ? ey - sy : sy - ey;
    xmaj = (dx >= dy);
    dmaj = xmaj ? dx : dy;
    dmin = xmaj ? dy : dx;
    smaj = xmaj ? sx : sy;
    smin = xmaj ? sy : sx;
    gmaj = xmaj ? ((ex >= sx) ? 1 : -1) : ((ey >= sy) ? 1 : -1);
    gmin = xmaj ? ((ey >= sy) ? 1 : -1) : ((ex >= sx) ? 1 : -1);
    nb = (dmaj + LANES) / LANES;
    for (int b = 0; b < nb; b++) begin
      for (int i = 0; i < LANES; i++) begin
        k  = b * LANES + i;
        m  = (dmaj == 0) ? 0 : (2 * k * dmin + dmaj) / (2 * dmaj);
        a  = smaj + k * gmaj;
        c  = smin + m * gmin;
        px = xmaj ? a : c;
        py = xmaj ? c : a;
        on = (k <= dmaj) && (px >= 0) && (px < SCREEN_W) && (py >= 0) && (py < SCREEN_H);
        e.mask[i] = on;
        e.chk[i]  = (k <= dmaj);
        e.x[i]    = px[COORD_W-1:0];
        e.y[i]    = py[COORD_W-1:0];
        e.addr[i] = on ? ADDR_W'(py * SCREEN_W + px) : '0;
      end
      e.last  = (b == nb - 1);
      e.color = col;
      sb.push_back(e);
    end
  endtask

  // mode 0: pix_ready held high, 1: toggles 1010..., 2: random
  task automatic run_line(input int x0, input int y0, input int x1, input int y1,
                          input logic [COLOR_W-1:0] col, input int mode);
    int    cyc, first_v, budget, beat;
    bit    done, stalled;
    beat_t e;
    logic [LANES*COORD_W-1:0] hx, hy;
    logic [LANES*ADDR_W-1:0]  ha;
    logic [LANES-1:0]         hm;
    logic                     hl;
    logic [COLOR_W-1:0]       hc;
    push_line(x0, y0, x1, y1, col);
    budget  = 4 * sb.size() + 20;
    cyc     = 0;
    beat    = 0;
    first_v = -1;
    done    = 0;
    stalled = 0;
    @(negedge clk);
    compared++;
    if (cmd_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL cmd_ready_idle: got %b expected 1", cmd_ready);
    end
    cmd_valid = 1'b1;
    start_x   = COORD_W'(x0);
    start_y   = COORD_W'(y0);
    end_x     = COORD_W'(x1);
    end_y     = COORD_W'(y1);
    color     = col;
    while (!done && cyc < budget) begin
      @(negedge clk);
      cyc++;
      cmd_valid = 1'b0;
      if (stalled) begin
        compared++;
        if (pix_valid !== 1'b1 || pix_x !== hx || pix_y !== hy || pix_addr !== ha ||
            pix_mask !== hm || pix_last !== hl || pix_color !== hc) begin
          mismatched++;
          $display("[TB] FAIL stall_hold beat%0d: got valid=%b x=%h mask=%b expected valid=1 x=%h mask=%b",
                   beat, pix_valid, pix_x, pix_mask, hx, hm);
        end
      end
      if (mode == 0)      pix_ready = 1'b1;
      else if (mode == 1) pix_ready = cyc[0];
      else                pix_ready = 1'($urandom_range(0, 1));
      compared++;
      if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL in_flight cyc%0d: got cmd_ready=%b busy=%b expected 0/1", cyc, cmd_ready, busy);
      end
      if (pix_valid === 1'b1 && first_v < 0) first_v = cyc;
      stalled = 0;
      if (pix_valid === 1'b1 && pix_ready) begin
        compared++;
        if (sb.size() == 0) begin
          mismatched++;
          $display("[TB] FAIL extra_beat: got beat%0d expected none", beat);
          done = 1;
        end else begin
          e = sb.pop_front();
          for (int i = 0; i < LANES; i++) begin
            compared++;
            if (pix_mask[i] !== e.mask[i]) begin
              mismatched++;
              $display("[TB] FAIL mask beat%0d lane%0d: got %b expected %b", beat, i, pix_mask[i], e.mask[i]);
            end
            compared++;
            if (pix_addr[i*ADDR_W +: ADDR_W] !== e.addr[i]) begin
              mismatched++;
              $display("[TB] FAIL addr beat%0d lane%0d: got %0d expected %0d", beat, i,
                       pix_addr[i*ADDR_W +: ADDR_W], e.addr[i]);
            end
            if (e.chk[i]) begin
              compared++;
              if (pix_x[i*COORD_W +: COORD_W] !== e.x[i] || pix_y[i*COORD_W +: COORD_W] !== e.y[i]) begin
                mismatched++;
                $display("[TB] FAIL xy beat%0d lane%0d: got (%0d,%0d) expected (%0d,%0d)", beat, i,
                         $signed(pix_x[i*COORD_W +: COORD_W]), $signed(pix_y[i*COORD_W +: COORD_W]),
                         $signed(e.x[i]), $signed(e.y[i]));
              end
            end
          end
          compared++;
          if (pix_last !== e.last || pix_color !== e.color) begin
            mismatched++;
            $display("[TB] FAIL last_color beat%0d: got last=%b color=%h expected last=%b color=%h",
                     beat, pix_last, pix_color, e.last, e.color);
          end
          if (e.last) done = 1;
        end
        beat++;
      end else if (pix_valid === 1'b1) begin
        stalled = 1;
        hx = pix_x; hy = pix_y; ha = pix_addr; hm = pix_mask; hl = pix_last; hc = pix_color;
      end
    end
    compared++;
    if (!done) begin
      mismatched++;
      $display("[TB] FAIL timeout: got %0d beats after %0d cycles expected %0d more", beat, cyc, sb.size());
    end
    compared++;
    if (first_v !== 2) begin
      mismatched++;
      $display("[TB] FAIL first_beat_latency: got %0d expected 2", first_v);
    end
    @(negedge clk);
    pix_ready = 1'b1;
    compared++;
    if (cmd_ready !== 1'b1 || pix_valid !== 1'b0 || busy !== 1'b0 || sb.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL line_done: got cmd_ready=%b pix_valid=%b busy=%b left=%0d expected 1/0/0/0",
               cmd_ready, pix_valid, busy, sb.size());
    end
    sb.delete();
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    pix_ready = 1'b1;
    start_x   = '0;
    start_y   = '0;
    end_x     = '0;
    end_y     = '0;
    color     = '0;
    #22;
    compared++;
    if (pix_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0 || pix_mask !== '0 ||
        pix_last !== 1'b0 || pix_x !== '0 || pix_y !== '0 || pix_addr !== '0 || pix_color !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_state: got valid=%b ready=%b busy=%b mask=%b last=%b expected 0/1/0/0/0",
               pix_valid, cmd_ready, busy, pix_mask, pix_last);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_horizontal;
    run_line(0, 0, 3, 0, 4'h5, 0);
    run_line(3, 0, 0, 0, 4'h6, 0);
  endtask

  task automatic test_y_major;
    run_line(0, 0, 2, -5, 4'h7, 0);
    run_line(-4, 7, 1, -3, 4'h2, 0);
  endtask

  task automatic test_backpressure;
    run_line(0, 0, 2, -5, 4'h8, 1);
    run_line(10, -20, -30, 40, 4'h3, 2);
  endtask

  task automatic test_clipping;
    run_line(-330, 0, -318, 0, 4'hA, 0);
    run_line(300, 230, 330, 250, 4'hB, 1);
  endtask

  task automatic test_single_pixel;
    run_line(5, 5, 5, 5, 4'hC, 0);
  endtask

  task automatic test_extreme;
    run_line(-4096, 4095, 4095, -4096, 4'hF, 0);
    run_line(4095, 100, -4096, 98, 4'h1, 0);
  endtask

  task automatic test_random;
    for (int n = 0; n < 6; n++) begin
      run_line(int'($urandom_range(0, 800)) - 400, int'($urandom_range(0, 600)) - 300,
               int'($urandom_range(0, 800)) - 400, int'($urandom_range(0, 600)) - 300,
               4'($urandom_range(0, 15)), 2);
    end
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    pix_ready = 1'b1;
    cmd_valid = 1'b1;
    start_x   = COORD_W'(-300);
    start_y   = COORD_W'(0);
    end_x     = COORD_W'(300);
    end_y     = COORD_W'(10);
    color     = 4'hD;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    compared++;
    if (pix_valid !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL pre_reset_valid: got %b expected 1", pix_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    compared++;
    if (pix_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0 || pix_mask !== '0 || pix_last !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL async_reset: got valid=%b ready=%b busy=%b mask=%b expected 0/1/0/00",
               pix_valid, cmd_ready, busy, pix_mask);
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    run_line(0, 0, 3, 0, 4'h9, 0);
  endtask

  initial begin
    test_reset();
    test_horizontal();
    test_y_major();
    test_backpressure();
    test_clipping();
    test_single_pixel();
    test_extreme();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
